gpu_core: RTL and testbench

//  APB-programmed 2D fill engine that rasterises rectangles into a double-buffered external SRAM frame store.
//  A CPU writes coordinates, colour and a command over APB. The engine then emits one SRAM pixel write per clock.

---
 rtl/gpu_pkg.sv | 27 ++
 rtl/gpu_if.sv | 41 ++++
 rtl/gpu_raster.sv | 74 +++++++
 rtl/gpu_core.sv | 184 ++++++++++++++++++
 tb/tb_gpu_core.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared constants, register map, command codes and FSM states for the fill engine
package gpu_pkg;

    // Default geometry: 1024 x 512 frame, 24-bit {R,G,B} pixels
    localparam int DEFAULT_CHANNEL_BITS = 8;
    localparam int DEFAULT_WIDTH_BITS   = 10;
    localparam int DEFAULT_HEIGHT_BITS  = 9;

    // Register byte offsets
    localparam logic [7:0] REG_X1    = 8'h00;
    localparam logic [7:0] REG_Y1    = 8'h04;
    localparam logic [7:0] REG_X2    = 8'h08;
    localparam logic [7:0] REG_Y2    = 8'h0C;
    localparam logic [7:0] REG_COLOR = 8'h10;
    localparam logic [7:0] REG_CMD   = 8'h14;

    // Command codes (full 32-bit compare; anything else is ignored)
    localparam logic [31:0] CMD_FILL_RECT = 32'd1;
    localparam logic [31:0] CMD_SWAP      = 32'd2;
    localparam logic [31:0] CMD_CLEAR     = 32'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

endpackage

// File: rtl/gpu_if.sv
// rtl/gpu_if.sv - APB write port and SRAM write-side pins of the fill engine
// Ports (signals):
//   APB   : pAddr_i, pDataWrite_i, pSel_i, pEnable_i, pWrite_i (driven by master)
//   SRAM  : CE0_o, CE1_o, R_W_o, OE_o, LB_o, UB_o, SEM_o, ZZ_o,
//           rgbdataout_o, adddataout_o, buffer_select_o (driven by slave)
interface gpu_if #(
    parameter int CHANNEL_BITS = 8,
    parameter int WIDTH_BITS   = 10,
    parameter int HEIGHT_BITS  = 9
);
    logic [31:0]                         pAddr_i;
    logic [31:0]                         pDataWrite_i;
    logic                                pSel_i;
    logic                                pEnable_i;
    logic                                pWrite_i;

    logic                                CE0_o;
    logic                                CE1_o;
    logic                                R_W_o;
    logic                                OE_o;
    logic                                LB_o;
    logic                                UB_o;
    logic                                SEM_o;
    logic                                ZZ_o;
    logic [3*CHANNEL_BITS-1:0]           rgbdataout_o;
    logic [WIDTH_BITS+HEIGHT_BITS:0]     adddataout_o;
    logic                                buffer_select_o;

    modport slave (
        input  pAddr_i, pDataWrite_i, pSel_i, pEnable_i, pWrite_i,
        output CE0_o, CE1_o, R_W_o, OE_o, LB_o, UB_o, SEM_o, ZZ_o,
               rgbdataout_o, adddataout_o, buffer_select_o
    );

    modport master (
        output pAddr_i, pDataWrite_i, pSel_i, pEnable_i, pWrite_i,
        input  CE0_o, CE1_o, R_W_o, OE_o, LB_o, UB_o, SEM_o, ZZ_o,
               rgbdataout_o, adddataout_o, buffer_select_o
    );

endinterface

// File: rtl/gpu_raster.sv
// rtl/gpu_raster.sv - rectangle iterator, raster order (x inner, y outer), one coordinate per clock
// Ports:
//   clk, n_rst        clock, async active-low reset
//   i_start           load corners and begin iterating (ignored bounds are pre-sorted by caller)
//   i_xs/i_xe/i_ys/i_ye  inclusive corners, xs<=xe, ys<=ye
//   o_x, o_y, o_valid current coordinate and its qualifier
//   o_done            high while the final coordinate (xe,ye) is presented
module gpu_raster #(
    parameter int WIDTH_BITS  = 10,
    parameter int HEIGHT_BITS = 9
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   i_start,
    input  logic [WIDTH_BITS-1:0]  i_xs,
    input  logic [WIDTH_BITS-1:0]  i_xe,
    input  logic [HEIGHT_BITS-1:0] i_ys,
    input  logic [HEIGHT_BITS-1:0] i_ye,
    output logic [WIDTH_BITS-1:0]  o_x,
    output logic [HEIGHT_BITS-1:0] o_y,
    output logic                   o_valid,
    output logic                   o_done
);

    logic [WIDTH_BITS-1:0]  r_x;
    logic [WIDTH_BITS-1:0]  r_xs;
    logic [WIDTH_BITS-1:0]  r_xe;
    logic [HEIGHT_BITS-1:0] r_y;
    logic [HEIGHT_BITS-1:0] r_ye;
    logic                   r_valid;

    logic w_last_x;
    logic w_last_y;

    // End-of-row/column is detected by equality before incrementing, so a
    // corner at the all-ones coordinate never relies on counter overflow.
    assign w_last_x = (r_x == r_xe);
    assign w_last_y = (r_y == r_ye);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_x     <= '0;
            r_xs    <= '0;
            r_xe    <= '0;
            r_y     <= '0;
            r_ye    <= '0;
            r_valid <= 1'b0;
        end else if (i_start) begin
            r_x     <= i_xs;
            r_xs    <= i_xs;
            r_xe    <= i_xe;
            r_y     <= i_ys;
            r_ye    <= i_ye;
            r_valid <= 1'b1;
        end else if (r_valid) begin
            if (w_last_x) begin
                if (w_last_y) begin
                    r_valid <= 1'b0;
                end else begin
                    r_x <= r_xs;
                    r_y <= r_y + 1'b1;
                end
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    assign o_x     = r_x;
    assign o_y     = r_y;
    assign o_valid = r_valid;
    assign o_done  = r_valid & w_last_x & w_last_y;

endmodule

// File: rtl/gpu_core.sv
// rtl/gpu_core.sv - APB-programmed rectangle fill engine writing into a double-buffered dual-port SRAM
// Ports:
//   clk    system clock, rising edge
//   n_rst  asynchronous reset, active low
//   bus    gpu_if.slave: APB write port in, SRAM write-side pins out
module gpu_core
    import gpu_pkg::*;
#(
    parameter int CHANNEL_BITS = DEFAULT_CHANNEL_BITS,
    parameter int WIDTH_BITS   = DEFAULT_WIDTH_BITS,
    parameter int HEIGHT_BITS  = DEFAULT_HEIGHT_BITS
) (
    input  logic  clk,
    input  logic  n_rst,
    gpu_if.slave  bus
);

    localparam int PIX_BITS  = 3 * CHANNEL_BITS;
    localparam int ADDR_BITS = WIDTH_BITS + HEIGHT_BITS + 1;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH_BITS-1:0]  r_x1;
    logic [WIDTH_BITS-1:0]  r_x2;
    logic [HEIGHT_BITS-1:0] r_y1;
    logic [HEIGHT_BITS-1:0] r_y2;
    logic [PIX_BITS-1:0]    r_color;
    logic [PIX_BITS-1:0]    r_color_snap;
    logic                   r_buf;

    logic                   r_ce0;
    logic                   r_ce1;
    logic                   r_rw;
    logic                   r_lb;
    logic                   r_ub;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [PIX_BITS-1:0]    r_rgb;

    logic                   w_apb_wr;
    logic [7:0]             w_off;
    logic                   w_cmd_idle;
    logic                   w_fill_cmd;
    logic                   w_clear_cmd;
    logic                   w_swap_cmd;
    logic                   w_start;
    logic [WIDTH_BITS-1:0]  w_xs;
    logic [WIDTH_BITS-1:0]  w_xe;
    logic [HEIGHT_BITS-1:0] w_ys;
    logic [HEIGHT_BITS-1:0] w_ye;
    logic [WIDTH_BITS-1:0]  w_x;
    logic [HEIGHT_BITS-1:0] w_y;
    logic                   w_pix_valid;
    logic                   w_pix_done;
    logic                   w_unused_addr;

    assign w_apb_wr      = bus.pSel_i & bus.pEnable_i & bus.pWrite_i;
    assign w_off         = bus.pAddr_i[7:0];
    assign w_unused_addr = ^bus.pAddr_i[31:8];

    // Commands are only honoured in IDLE; anything arriving mid-fill is dropped,
    // which also keeps the buffer flag stable for the whole fill.
    assign w_cmd_idle  = w_apb_wr && (w_off == REG_CMD) && (r_state == ST_IDLE);
    assign w_fill_cmd  = w_cmd_idle && (bus.pDataWrite_i == CMD_FILL_RECT);
    assign w_clear_cmd = w_cmd_idle && (bus.pDataWrite_i == CMD_CLEAR);
    assign w_swap_cmd  = w_cmd_idle && (bus.pDataWrite_i == CMD_SWAP);
    assign w_start     = w_fill_cmd | w_clear_cmd;

    // Corners are sorted here so the iterator always walks low-to-high.
    always_comb begin
        w_xs = (r_x1 < r_x2) ? r_x1 : r_x2;
        w_xe = (r_x1 < r_x2) ? r_x2 : r_x1;
        w_ys = (r_y1 < r_y2) ? r_y1 : r_y2;
        w_ye = (r_y1 < r_y2) ? r_y2 : r_y1;
        if (w_clear_cmd) begin
            w_xs = '0;
            w_xe = '1;
            w_ys = '0;
            w_ye = '1;
        end
    end

    gpu_raster #(
        .WIDTH_BITS  (WIDTH_BITS),
        .HEIGHT_BITS (HEIGHT_BITS)
    ) u_raster (
        .clk     (clk),
        .n_rst   (n_rst),
        .i_start (w_start),
        .i_xs    (w_xs),
        .i_xe    (w_xe),
        .i_ys    (w_ys),
        .i_ye    (w_ye),
        .o_x     (w_x),
        .o_y     (w_y),
        .o_valid (w_pix_valid),
        .o_done  (w_pix_done)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start)    w_state_next = ST_FILL;
            ST_FILL: if (w_pix_done) w_state_next = ST_IDLE;
            default:                 w_state_next = ST_IDLE;
        endcase
    end

    // Register file, colour snapshot and front/back buffer flag
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_x1         <= '0;
            r_x2         <= '0;
            r_y1         <= '0;
            r_y2         <= '0;
            r_color      <= '0;
            r_color_snap <= '0;
            r_buf        <= 1'b0;
        end else begin
            if (w_apb_wr) begin
                case (w_off)
                    REG_X1:    r_x1    <= bus.pDataWrite_i[WIDTH_BITS-1:0];
                    REG_Y1:    r_y1    <= bus.pDataWrite_i[HEIGHT_BITS-1:0];
                    REG_X2:    r_x2    <= bus.pDataWrite_i[WIDTH_BITS-1:0];
                    REG_Y2:    r_y2    <= bus.pDataWrite_i[HEIGHT_BITS-1:0];
                    REG_COLOR: r_color <= bus.pDataWrite_i[PIX_BITS-1:0];
                    default:   ;
                endcase
            end
            if (w_start)    r_color_snap <= r_color;
            if (w_swap_cmd) r_buf        <= ~r_buf;
        end
    end

    // SRAM pins are registered; one write strobe per valid iterator coordinate.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_ce0  <= 1'b1;
            r_ce1  <= 1'b0;
            r_rw   <= 1'b1;
            r_lb   <= 1'b1;
            r_ub   <= 1'b1;
            r_addr <= '0;
            r_rgb  <= '0;
        end else if (w_pix_valid) begin
            r_ce0  <= 1'b0;
            r_ce1  <= 1'b1;
            r_rw   <= 1'b0;
            r_lb   <= 1'b0;
            r_ub   <= 1'b0;
            r_addr <= {r_buf, w_y, w_x};
            r_rgb  <= r_color_snap;
        end else begin
            r_ce0  <= 1'b1;
            r_ce1  <= 1'b0;
            r_rw   <= 1'b1;
            r_lb   <= 1'b1;
            r_ub   <= 1'b1;
            r_addr <= '0;
            r_rgb  <= '0;
        end
    end

    assign bus.CE0_o           = r_ce0;
    assign bus.CE1_o           = r_ce1;
    assign bus.R_W_o           = r_rw;
    assign bus.LB_o            = r_lb;
    assign bus.UB_o            = r_ub;
    assign bus.adddataout_o    = r_addr;
    assign bus.rgbdataout_o    = r_rgb;
    assign bus.buffer_select_o = r_buf;
    assign bus.OE_o            = 1'b1;
    assign bus.SEM_o           = 1'b1;
    assign bus.ZZ_o            = 1'b0;

endmodule

// File: tb/tb_gpu_core.sv
// tb/tb_gpu_core.sv - directed self-checking bench for the rectangle fill engine
module tb_gpu_core;
    import gpu_pkg::*;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    gpu_if bus ();

    gpu_core dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int tests_run = 0;
    int failed    = 0;

    logic [19:0] got_addr[$];
    logic [23:0] got_rgb[$];
    int          first_cyc;
    int          ctl_bad;

    task automatic apb_write(input logic [7:0] off, input logic [31:0] data);
        @(negedge clk);
        bus.pAddr_i      = {24'h0, off};
        bus.pDataWrite_i = data;
        bus.pSel_i       = 1'b1;
        bus.pWrite_i     = 1'b1;
        bus.pEnable_i    = 1'b0;
        @(negedge clk);
        bus.pEnable_i    = 1'b1;
        @(posedge clk);
        #1;
        bus.pSel_i       = 1'b0;
        bus.pEnable_i    = 1'b0;
        bus.pWrite_i     = 1'b0;
    endtask

    task automatic set_rect(input logic [31:0] x1, input logic [31:0] y1,
                            input logic [31:0] x2, input logic [31:0] y2);
        apb_write(REG_X1, x1);
        apb_write(REG_Y1, y1);
        apb_write(REG_X2, x2);
        apb_write(REG_Y2, y2);
    endtask

    // Records write cycles from the negedge after the CMD edge until the bus goes idle again.
    task automatic collect(input int budget);
        got_addr.delete();
        got_rgb.delete();
        first_cyc = -1;
        ctl_bad   = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (bus.R_W_o === 1'b0) begin
                if (first_cyc < 0) first_cyc = c;
                got_addr.push_back(bus.adddataout_o);
                got_rgb.push_back(bus.rgbdataout_o);
                if (bus.CE0_o !== 1'b0 || bus.CE1_o !== 1'b1 || bus.LB_o !== 1'b0 ||
                    bus.UB_o !== 1'b0 || bus.OE_o !== 1'b1 || bus.SEM_o !== 1'b1 || bus.ZZ_o !== 1'b0)
                    ctl_bad++;
            end else if (got_addr.size() > 0) begin
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.pAddr_i = '0; bus.pDataWrite_i = '0;
        bus.pSel_i = 1'b0; bus.pEnable_i = 1'b0; bus.pWrite_i = 1'b0;
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus.R_W_o !== 1'b1 || bus.CE0_o !== 1'b1 || bus.CE1_o !== 1'b0) begin
            failed++;
            $display("FAIL reset_ctrl: R_W=%b CE0=%b CE1=%b, required 1 1 0", bus.R_W_o, bus.CE0_o, bus.CE1_o);
        end
        tests_run++;
        if (bus.buffer_select_o !== 1'b0 || bus.adddataout_o !== 20'h0 || bus.rgbdataout_o !== 24'h0) begin
            failed++;
            $display("FAIL reset_data: bs=%b addr=%h rgb=%h, required 0 0 0",
                     bus.buffer_select_o, bus.adddataout_o, bus.rgbdataout_o);
        end
        tests_run++;
        if (bus.OE_o !== 1'b1 || bus.SEM_o !== 1'b1 || bus.ZZ_o !== 1'b0 || bus.LB_o !== 1'b1 || bus.UB_o !== 1'b1) begin
            failed++;
            $display("FAIL reset_static: OE=%b SEM=%b ZZ=%b LB=%b UB=%b, required 1 1 0 1 1",
                     bus.OE_o, bus.SEM_o, bus.ZZ_o, bus.LB_o, bus.UB_o);
        end
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fill_row();
        logic [19:0] exp_a[3];
        exp_a[0] = (20'd3 << 10) | 20'd2;
        exp_a[1] = (20'd3 << 10) | 20'd3;
        exp_a[2] = (20'd3 << 10) | 20'd4;
        set_rect(2, 3, 4, 3);
        apb_write(REG_COLOR, 32'h00FF0000);
        apb_write(REG_CMD, 32'd1);
        collect(20);
        tests_run++;
        if (got_addr.size() != 3) begin
            failed++;
            $display("FAIL row_count: got %0d writes, required 3", got_addr.size());
        end
        tests_run++;
        if (first_cyc != 1) begin
            failed++;
            $display("FAIL row_latency: first write at cycle %0d, required 1", first_cyc);
        end
        for (int i = 0; i < 3 && i < got_addr.size(); i++) begin
            tests_run++;
            if (got_addr[i] !== exp_a[i] || got_rgb[i] !== 24'hFF0000) begin
                failed++;
                $display("FAIL row_pix%0d: addr=%h rgb=%h, required addr=%h rgb=ff0000", i, got_addr[i], got_rgb[i], exp_a[i]);
            end
        end
        tests_run++;
        if (ctl_bad != 0) begin
            failed++;
            $display("FAIL row_ctrl: %0d write cycles with wrong strobes, required 0", ctl_bad);
        end
        tests_run++;
        if (bus.R_W_o !== 1'b1 || bus.CE0_o !== 1'b1 || bus.adddataout_o !== 20'h0 || bus.rgbdataout_o !== 24'h0) begin
            failed++;
            $display("FAIL row_idle: R_W=%b CE0=%b addr=%h rgb=%h, required 1 1 0 0",
                     bus.R_W_o, bus.CE0_o, bus.adddataout_o, bus.rgbdataout_o);
        end
    endtask

    task automatic test_fill_reversed();
        logic [19:0] exp_a[4];
        exp_a[0] = (20'd5 << 10) | 20'd4;
        exp_a[1] = (20'd5 << 10) | 20'd5;
        exp_a[2] = (20'd6 << 10) | 20'd4;
        exp_a[3] = (20'd6 << 10) | 20'd5;
        set_rect(5, 6, 4, 5);
        apb_write(REG_COLOR, 32'h0000A5C3);
        apb_write(REG_CMD, 32'd1);
        collect(20);
        tests_run++;
        if (got_addr.size() != 4) begin
            failed++;
            $display("FAIL rev_count: got %0d writes, required 4", got_addr.size());
        end
        for (int i = 0; i < 4 && i < got_addr.size(); i++) begin
            tests_run++;
            if (got_addr[i] !== exp_a[i] || got_rgb[i] !== 24'h00A5C3) begin
                failed++;
                $display("FAIL rev_pix%0d: addr=%h rgb=%h, required addr=%h rgb=00a5c3", i, got_addr[i], got_rgb[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_swap();
        apb_write(REG_CMD, 32'd2);
        @(negedge clk);
        tests_run++;
        if (bus.buffer_select_o !== 1'b1) begin
            failed++;
            $display("FAIL swap_set: buffer_select=%b, required 1", bus.buffer_select_o);
        end
        set_rect(0, 0, 0, 0);
        apb_write(REG_CMD, 32'd1);
        collect(20);
        tests_run++;
        if (got_addr.size() != 1 || got_addr[0] !== 20'h80000) begin
            failed++;
            $display("FAIL swap_addr: %0d writes addr=%h, required 1 write addr=80000",
                     got_addr.size(), (got_addr.size() > 0) ? got_addr[0] : 20'h0);
        end
        apb_write(REG_CMD, 32'd2);
        @(negedge clk);
        tests_run++;
        if (bus.buffer_select_o !== 1'b0) begin
            failed++;
            $display("FAIL swap_clear: buffer_select=%b, required 0", bus.buffer_select_o);
        end
    endtask

    task automatic test_edge_wrap();
        // 0x7FE truncates to x=1022, 0x3FF truncates to y=511
        set_rect(32'h7FE, 32'h3FF, 32'd1023, 32'd511);
        apb_write(REG_CMD, 32'd1);
        collect(20);
        tests_run++;
        if (got_addr.size() != 2) begin
            failed++;
            $display("FAIL wrap_count: got %0d writes, required 2", got_addr.size());
        end else begin
            tests_run++;
            if (got_addr[0] !== ((20'd511 << 10) | 20'd1022) || got_addr[1] !== ((20'd511 << 10) | 20'd1023)) begin
                failed++;
                $display("FAIL wrap_addr: %h %h, required %h %h", got_addr[0], got_addr[1],
                         (20'd511 << 10) | 20'd1022, (20'd511 << 10) | 20'd1023);
            end
        end
    endtask

    task automatic test_back_to_back();
        int bad_order = 0;
        int bad_rgb   = 0;
        int late      = 0;
        set_rect(10, 20, 19, 29);
        apb_write(REG_COLOR, 32'h000F0F0F);
        apb_write(REG_CMD, 32'd1);
        fork
            collect(300);
            begin
                repeat (5) @(negedge clk);
                apb_write(REG_CMD, 32'd2);
                apb_write(REG_COLOR, 32'h00123456);
                apb_write(REG_CMD, 32'd1);
            end
        join
        tests_run++;
        if (got_addr.size() != 100) begin
            failed++;
            $display("FAIL b2b_count: got %0d writes, required 100", got_addr.size());
        end
        for (int i = 0; i < got_addr.size() && i < 100; i++) begin
            if (got_addr[i] !== ((20'(20 + i / 10) << 10) | 20'(10 + i % 10))) bad_order++;
            if (got_rgb[i] !== 24'h0F0F0F) bad_rgb++;
        end
        tests_run++;
        if (bad_order != 0 || bad_rgb != 0) begin
            failed++;
            $display("FAIL b2b_data: %0d bad addresses, %0d bad colours, required 0 0", bad_order, bad_rgb);
        end
        tests_run++;
        if (bus.buffer_select_o !== 1'b0) begin
            failed++;
            $display("FAIL b2b_buffer: buffer_select=%b, required 0", bus.buffer_select_o);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.R_W_o !== 1'b1) late++;
        end
        tests_run++;
        if (late != 0) begin
            failed++;
            $display("FAIL b2b_dropped: %0d writes after fill, required 0", late);
        end
    endtask

    task automatic test_reset_mid_fill();
        int stray = 0;
        apb_write(REG_CMD, 32'd2);
        set_rect(0, 0, 9, 9);
        apb_write(REG_CMD, 32'd1);
        repeat (20) @(negedge clk);
        tests_run++;
        if (bus.R_W_o !== 1'b0 || bus.buffer_select_o !== 1'b1) begin
            failed++;
            $display("FAIL rstmid_busy: R_W=%b bs=%b, required 0 1", bus.R_W_o, bus.buffer_select_o);
        end
        #2;
        n_rst = 1'b0;
        #1;
        tests_run++;
        if (bus.R_W_o !== 1'b1 || bus.CE0_o !== 1'b1 || bus.adddataout_o !== 20'h0 ||
            bus.rgbdataout_o !== 24'h0 || bus.buffer_select_o !== 1'b0) begin
            failed++;
            $display("FAIL rstmid_idle: R_W=%b CE0=%b addr=%h rgb=%h bs=%b, required 1 1 0 0 0",
                     bus.R_W_o, bus.CE0_o, bus.adddataout_o, bus.rgbdataout_o, bus.buffer_select_o);
        end
        @(negedge clk);
        n_rst = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.R_W_o !== 1'b1) stray++;
        end
        tests_run++;
        if (stray != 0) begin
            failed++;
            $display("FAIL rstmid_stray: %0d writes after reset, required 0", stray);
        end
        // Registers were cleared, so a bare CMD draws the single pixel (0,0)
        apb_write(REG_CMD, 32'd1);
        collect(20);
        tests_run++;
        if (got_addr.size() != 1 || got_addr[0] !== 20'h0) begin
            failed++;
            $display("FAIL rstmid_restart: %0d writes, required 1 at address 0", got_addr.size());
        end
    endtask

    initial begin
        test_reset();
        test_fill_row();
        test_fill_reversed();
        test_swap();
        test_edge_wrap();
        test_back_to_back();
        test_reset_mid_fill();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
